// File: rtl/zprize_msm_point_issue_sched_pkg.sv
// Shared types and defaults for the MSM point issue scheduler.
package zprize_param;

  // Scheduler control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  localparam int NUM_CH_DEF     = 4;
  localparam int CORE_NUM_DEF   = 4;
  localparam int CREDIT_MAX_DEF = 8;

  // Bits needed to hold a credit count in the range 0..credit_max inclusive.
  function automatic int credit_w(input int credit_max);
    return $clog2(credit_max + 1);
  endfunction

endpackage

// File: rtl/zprize_msm_point_issue_sched_credit_cnt.sv
// Per-core up/down credit counter. Starts full, saturates at CREDIT_MAX and
// flags a return that arrives while already full.
module zprize_msm_credit_cnt
  import zprize_param::*;
#(
  parameter  int CREDIT_MAX = CREDIT_MAX_DEF,
  localparam int CW         = credit_w(CREDIT_MAX)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_issue,
  input  logic i_return,
  output logic o_nonzero,
  output logic o_full,
  output logic o_ovf
);

  localparam logic [CW-1:0] FULL_VAL = CW'(CREDIT_MAX);

  logic [CW-1:0] r_cnt;
  logic          w_full;

  assign w_full    = (r_cnt == FULL_VAL);
  assign o_full    = w_full;
  assign o_nonzero = (r_cnt != '0);
  // A lone return against a full counter has nowhere to go.
  assign o_ovf     = i_return && !i_issue && w_full;

  // Count down on issue, up on return; simultaneous issue and return cancel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= FULL_VAL;
    end else if (i_issue && !i_return) begin
      if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
    end else if (i_return && !i_issue) begin
      if (!w_full) r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/zprize_msm_point_issue_sched.sv
// Round-robin point issue from NUM_CH FIFO channels into one broadcast point
// pipe, gated by per-core credits. Channels are never skipped so DDR order is
// preserved; one job of num_points points runs per accepted start.
module zprize_msm_point_issue_sched
  import zprize_param::*;
#(
  parameter  int NUM_CH     = NUM_CH_DEF,
  parameter  int CORE_NUM   = CORE_NUM_DEF,
  parameter  int DATA_W     = 1152,
  parameter  int CREDIT_MAX = CREDIT_MAX_DEF,
  parameter  int CNT_W      = 32,
  localparam int SEL_W      = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [CNT_W-1:0]         num_points,
  input  logic [NUM_CH-1:0]        ch_rvalid,
  input  logic [NUM_CH*DATA_W-1:0] ch_rdata,
  output logic [NUM_CH-1:0]        ch_rready,
  input  logic [CORE_NUM-1:0]      credit_return,
  output logic                     point_valid,
  output logic [DATA_W-1:0]        point_data,
  output logic [SEL_W-1:0]         point_ch,
  output logic                     busy,
  output logic                     done,
  output logic                     credit_err
);

  sched_state_t      r_state;
  sched_state_t      w_state_next;
  logic [SEL_W-1:0]  r_sel;
  logic [CNT_W-1:0]  r_remaining;
  logic              r_point_valid;
  logic [DATA_W-1:0] r_point_data;
  logic [SEL_W-1:0]  r_point_ch;
  logic              r_busy;
  logic              r_done;
  logic              r_credit_err;

  logic [DATA_W-1:0]   w_ch_data [NUM_CH];
  logic [CORE_NUM-1:0] w_nonzero;
  logic [CORE_NUM-1:0] w_full;
  logic [CORE_NUM-1:0] w_ovf;
  logic                w_issue;
  logic                w_start_ok;

  // Unpack the flat channel bus into one slice per channel.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign w_ch_data[gi] = ch_rdata[gi*DATA_W +: DATA_W];
  end

  // Every point is broadcast, so every core's counter sees every issue.
  for (genvar gi = 0; gi < CORE_NUM; gi++) begin : g_core
    zprize_msm_credit_cnt #(
      .CREDIT_MAX (CREDIT_MAX)
    ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .i_issue   (w_issue),
      .i_return  (credit_return[gi]),
      .o_nonzero (w_nonzero[gi]),
      .o_full    (w_full[gi]),
      .o_ovf     (w_ovf[gi])
    );
  end

  assign w_start_ok = (r_state == IDLE) && start;
  // Only the channel under the pointer may be served; an empty one stalls us.
  assign w_issue    = (r_state == RUN) && (r_remaining != '0) &&
                      ch_rvalid[r_sel] && (&w_nonzero);
  assign ch_rready  = w_issue ? (NUM_CH'(1) << r_sel) : '0;

  assign point_valid = r_point_valid;
  assign point_data  = r_point_data;
  assign point_ch    = r_point_ch;
  assign busy        = r_busy;
  assign done        = r_done;
  assign credit_err  = r_credit_err;

  // Next-state decode for the job sequencer.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = RUN;
      RUN: begin
        if (r_remaining == '0) begin
          w_state_next = DRAIN;
        end else if (w_issue && (r_remaining == CNT_W'(1))) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN:   if (&w_full) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State, round-robin pointer and job point counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_sel       <= '0;
      r_remaining <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_issue) r_sel <= r_sel + SEL_W'(1);
      if (w_start_ok) begin
        r_remaining <= num_points;
      end else if (w_issue) begin
        r_remaining <= r_remaining - CNT_W'(1);
      end
    end
  end

  // Registered point pipe: one cycle from FIFO pop to point_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_point_valid <= 1'b0;
      r_point_data  <= '0;
      r_point_ch    <= '0;
    end else begin
      r_point_valid <= w_issue;
      if (w_issue) begin
        r_point_data <= w_ch_data[r_sel];
        r_point_ch   <= r_sel;
      end
    end
  end

  // Status flags decoded from the upcoming state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_credit_err <= 1'b0;
    end else begin
      r_busy <= (w_state_next == RUN) || (w_state_next == DRAIN);
      r_done <= (w_state_next == DONE);
      if (|w_ovf) begin
        r_credit_err <= 1'b1;
      end else if (w_start_ok) begin
        r_credit_err <= 1'b0;
      end
    end
  end

endmodule

// File: doc/zprize_msm_point_issue_sched.md
Name: zprize_msm_point_issue_sched

Overview:
- Schedules point delivery from NUM_CH point-buffer FIFO channels into the single broadcast point pipe feeding CORE_NUM MSM cores.
- Visits channels in strict round-robin order, with no skipping, so DDR point order is preserved.
- Gates each issue on per-core credit counters; each core returns credits as it consumes points.
- Runs one job of num_points points per start, waits for all credits to come back, then reports done.

Parameters:
- NUM_CH, 4, number of point FIFO channels; power of 2, at least 2.
- CORE_NUM, 4, number of cores receiving the broadcast point pipe.
- DATA_W, 1152, point width in bits.
- CREDIT_MAX, 8, per-core input buffer depth in points; at least 1.
- CNT_W, 32, width of the job point counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  pulse; launches a job, honoured only in IDLE.
- num_points  in  CNT_W  points in the job; sampled on an accepted start.
- ch_rvalid  in  NUM_CH  per-channel FIFO not-empty.
- ch_rdata  in  NUM_CH*DATA_W  per-channel FIFO head; channel i occupies bits [i*DATA_W +: DATA_W].
- ch_rready  out  NUM_CH  per-channel pop strobe; combinational, one-hot or zero.
- credit_return  in  CORE_NUM  per-core pulse; each pulse returns one credit.
- point_valid  out  1  registered; point_data is valid this cycle.
- point_data  out  DATA_W  registered point.
- point_ch  out  $clog2(NUM_CH)  channel the registered point came from.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse at job end.
- credit_err  out  1  sticky credit overflow flag; cleared by an accepted start.

Behaviour:
- Reset values:
  - state=IDLE, sel=0, remaining=0.
  - Every credit counter = CREDIT_MAX.
  - point_valid=0, point_data=0, point_ch=0, busy=0, done=0, credit_err=0.
  - ch_rready=0.
- Reset mid-job: all of the above is restored immediately. In-flight points are dropped, and no done pulse is produced.
- States:
  - IDLE: on start, load remaining=num_points, clear credit_err, go to RUN.
  - RUN: issue points. When an issue makes remaining 0, go to DRAIN. If entered with remaining=0, go to DRAIN on the next cycle.
  - DRAIN: wait until every credit counter equals CREDIT_MAX, then go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- Issue condition (combinational): state==RUN && remaining!=0 && ch_rvalid[sel] && every credit counter > 0.
- On an issue:
  - ch_rready[sel]=1 in the same cycle.
  - Next cycle: point_valid=1, point_data = the channel sel slice of ch_rdata, point_ch=sel.
  - sel increments and wraps from NUM_CH-1 to 0.
  - remaining decrements.
  - Latency from FIFO pop to point_valid is 1 cycle.
- Without an issue:
  - point_valid=0 the next cycle.
  - point_data holds its value.
  - sel does not advance. Waiting on an empty channel stalls the scheduler; other channels are never served in its place.
- Credit counters, width $clog2(CREDIT_MAX+1), are updated per core every cycle:
  - issue and no return: decrement.
  - return and no issue: increment.
  - both in the same cycle: unchanged.
  - A return with no issue while the counter is already CREDIT_MAX saturates the counter and sets credit_err.
- Credits persist across jobs and are not reset by start.
- start while not in IDLE is ignored; remaining is not reloaded.
- busy is a registered decode of the state; point_valid never asserts outside RUN or the cycle after the last issue.

Decomposition:
- Package zprize_param gains:
  - the state enum (IDLE, RUN, DRAIN, DONE),
  - NUM_CH, CORE_NUM, CREDIT_MAX defaults,
  - a credit-width localparam function.
- One sub-module, zprize_msm_credit_cnt: a single up/down saturating credit counter with an overflow flag, instantiated CORE_NUM times. It exposes a nonzero output and an is-full output for the issue and drain logic.

Test Plan:
1. Streaming: all ch_rvalid=1, credits returned each cycle, num_points=8 -> point_valid high for 8 consecutive cycles, point_ch sequence 0,1,2,3,0,1,2,3; done pulses once credits are all back; sel=0 afterwards.
2. Stalled channel: channel 2 empty for 5 cycles, others full -> ch_rready[2] asserts only once ch_rvalid[2] rises; channels 3 and 0 are never popped during the stall; point order is still 0,1,2,3.
3. Credit exhaustion: CREDIT_MAX=8, no returns, num_points=12 -> exactly 8 issues, then a stall; core 1 returns 3 credits while the other cores return none -> still stalled; after every core returns 4 credits -> the remaining 4 issue, then DRAIN.
4. Boundaries:
   - num_points=0 -> done pulses within 3 cycles of start, with zero pops.
   - start during RUN -> ignored; point count unchanged.
5. Simultaneous issue and return on the same core in the same cycle -> counter unchanged. Extra return at CREDIT_MAX -> credit_err=1, counter stays 8, flag cleared by the next start.
6. Assert rst mid-RUN with 3 points left -> outputs at reset values in the same cycle; a new start with num_points=4 delivers point_ch sequence 0,1,2,3.
